// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the issue queue: geometry, opcode bounds, entry layout.
package issue_queue_pkg;

    localparam int IQ_DEPTH_LOG = 3;
    localparam int DEPTH        = 1 << IQ_DEPTH_LOG;
    localparam int ROB_IDX_W    = 4;
    localparam int OP_W         = 6;
    localparam int ENTRY_W      = 86;

    // Load/store opcodes occupy one contiguous range LB..SW.
    localparam logic [OP_W-1:0] OP_LB  = 6'd10;
    localparam logic [OP_W-1:0] OP_LW  = 6'd12;
    localparam logic [OP_W-1:0] OP_SW  = 6'd17;
    localparam logic [OP_W-1:0] OP_ADD = 6'd20;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [31:0]     pc;
        logic            pred;
    } iq_entry_t;

    function automatic logic is_ls(input logic [OP_W-1:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

endpackage

// File: rtl/issue_queue_fifo.sv
// iq_fifo: in-order entry storage with head/tail pointers, occupancy count and flush.
// en_i low freezes everything; rst_i wins over flush_i, which wins over push/pop.
module iq_fifo
    import issue_queue_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      en_i,
    input  logic      flush_i,
    input  logic      push_i,
    input  iq_entry_t wdata_i,
    input  logic      pop_i,
    output iq_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    iq_entry_t                 mem_q [DEPTH];
    logic [IQ_DEPTH_LOG-1:0]   head_q, head_d;
    logic [IQ_DEPTH_LOG-1:0]   tail_q, tail_d;
    logic [IQ_DEPTH_LOG:0]     count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en_i) begin
            if (flush_i) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push_i) tail_d = tail_q + 1'b1;
                if (pop_i)  head_d = head_q + 1'b1;
                case ({push_i, pop_i})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry contents need no reset; only occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && en_i && !flush_i && push_i) mem_q[tail_q] <= wdata_i;
    end

    assign head_o  = mem_q[head_q];
    assign full_o  = (count_q == (IQ_DEPTH_LOG+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/issue_queue.sv
// issue_queue: buffers decoded instructions and dispatches the head to ROB and RS/SLB.
// Optional `ISSUE_BYPASS_EN lets an instruction arriving at an empty queue dispatch in the same cycle.
module issue_queue
    import issue_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 jump_rst,
    input  logic                 ID_valid,
    input  logic [OP_W-1:0]      op,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [4:0]           rd,
    input  logic [31:0]          imm,
    input  logic [31:0]          IF_curPC,
    input  logic                 IF_pred_result,
    output logic                 iq_full,
    output logic [4:0]           query_rs1,
    output logic [4:0]           query_rs2,
    input  logic [31:0]          issue_Vj,
    input  logic [ROB_IDX_W-1:0] issue_Qj,
    input  logic                 issue_Pj,
    input  logic [31:0]          issue_Vk,
    input  logic [ROB_IDX_W-1:0] issue_Qk,
    input  logic                 issue_Pk,
    input  logic [ROB_IDX_W-1:0] ROB_tail,
    input  logic                 ROB_full,
    input  logic                 RS_full,
    input  logic                 SLB_full,
    output logic [31:0]          Vj,
    output logic [ROB_IDX_W-1:0] Qj,
    output logic                 Pj,
    output logic [31:0]          Vk,
    output logic [ROB_IDX_W-1:0] Qk,
    output logic                 Pk,
    output logic [OP_W-1:0]      issue_op,
    output logic [4:0]           issue_reg,
    output logic [31:0]          issue_imm,
    output logic [31:0]          issue_curPC,
    output logic                 issue_pred,
    output logic [ROB_IDX_W-1:0] issue_reorder,
    output logic [4:0]           rename_reg,
    output logic [ROB_IDX_W-1:0] rename_reorder,
    output logic                 ROB_send,
    output logic                 RS_send,
    output logic                 SLB_send,
    output logic                 rename_send
);

    iq_entry_t in_entry;
    iq_entry_t fifo_head;
    iq_entry_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      sel_in;
    logic      head_ls;
    logic      can_disp;
    logic      enq;
    logic      push;
    logic      pop;

    assign in_entry = '{op: op, rs1: rs1, rs2: rs2, rd: rd, imm: imm,
                        pc: IF_curPC, pred: IF_pred_result};

`ifdef ISSUE_BYPASS_EN
    assign sel_in = fifo_empty & ID_valid;
`else
    assign sel_in = 1'b0;
`endif

    assign head    = sel_in ? in_entry : fifo_head;
    assign head_ls = is_ls(head.op);

    assign can_disp = rdy & ~rst & ~jump_rst & (~fifo_empty | sel_in) & ~ROB_full
                    & (head_ls ? ~SLB_full : ~RS_full);

    // Full blocks enqueue even if the head leaves this cycle.
    assign enq  = rdy & ~rst & ~jump_rst & ID_valid & ~fifo_full;
    assign push = enq & ~(sel_in & can_disp);
    assign pop  = can_disp & ~sel_in;

    iq_fifo u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (rdy),
        .flush_i (jump_rst),
        .push_i  (push),
        .wdata_i (in_entry),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign iq_full   = fifo_full;
    assign query_rs1 = head.rs1;
    assign query_rs2 = head.rs2;

    assign Vj = issue_Vj;
    assign Qj = issue_Qj;
    assign Pj = issue_Pj;
    assign Vk = issue_Vk;
    assign Qk = issue_Qk;
    assign Pk = issue_Pk;

    assign issue_op       = head.op;
    assign issue_reg      = head.rd;
    assign issue_imm      = head.imm;
    assign issue_curPC    = head.pc;
    assign issue_pred     = head.pred;
    assign issue_reorder  = ROB_tail;
    assign rename_reg     = head.rd;
    assign rename_reorder = ROB_tail;

    assign ROB_send    = can_disp;
    assign rename_send = can_disp;
    assign SLB_send    = can_disp & head_ls;
    assign RS_send     = can_disp & ~head_ls;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic against a queue-level model.
module tb_issue_queue;
  import issue_queue_pkg::*;

`ifdef ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, rdy, jump_rst, ID_valid;
  logic [OP_W-1:0]      op;
  logic [4:0]           rs1, rs2, rd;
  logic [31:0]          imm, IF_curPC;
  logic                 IF_pred_result;
  logic                 iq_full;
  logic [4:0]           query_rs1, query_rs2;
  logic [31:0]          issue_Vj, issue_Vk;
  logic [ROB_IDX_W-1:0] issue_Qj, issue_Qk;
  logic                 issue_Pj, issue_Pk;
  logic [ROB_IDX_W-1:0] ROB_tail;
  logic                 ROB_full, RS_full, SLB_full;
  logic [31:0]          Vj, Vk;
  logic [ROB_IDX_W-1:0] Qj, Qk;
  logic                 Pj, Pk;
  logic [OP_W-1:0]      issue_op;
  logic [4:0]           issue_reg;
  logic [31:0]          issue_imm, issue_curPC;
  logic                 issue_pred;
  logic [ROB_IDX_W-1:0] issue_reorder, rename_reorder;
  logic [4:0]           rename_reg;
  logic                 ROB_send, RS_send, SLB_send, rename_send;

  issue_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst), .ID_valid(ID_valid),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .IF_curPC(IF_curPC),
    .IF_pred_result(IF_pred_result), .iq_full(iq_full),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .issue_Vj(issue_Vj), .issue_Qj(issue_Qj), .issue_Pj(issue_Pj),
    .issue_Vk(issue_Vk), .issue_Qk(issue_Qk), .issue_Pk(issue_Pk),
    .ROB_tail(ROB_tail), .ROB_full(ROB_full), .RS_full(RS_full), .SLB_full(SLB_full),
    .Vj(Vj), .Qj(Qj), .Pj(Pj), .Vk(Vk), .Qk(Qk), .Pk(Pk),
    .issue_op(issue_op), .issue_reg(issue_reg), .issue_imm(issue_imm),
    .issue_curPC(issue_curPC), .issue_pred(issue_pred), .issue_reorder(issue_reorder),
    .rename_reg(rename_reg), .rename_reorder(rename_reorder),
    .ROB_send(ROB_send), .RS_send(RS_send), .SLB_send(SLB_send), .rename_send(rename_send)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rs_pulses = 0;
  int slb_pulses = 0;
  iq_entry_t exp_q[$];
  logic [31:0] next_pc = 32'h1000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic set_instr(input logic [OP_W-1:0] o);
    op = o;
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    rd  = 5'($urandom_range(1, 31));
    imm = $urandom;
    IF_curPC = next_pc;
    IF_pred_result = 1'($urandom_range(0, 1));
    next_pc = next_pc + 32'd4;
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    if ($urandom_range(0, 1) == 0) return OP_LB + 6'($urandom_range(0, 7));
    else if ($urandom_range(0, 1) == 0) return 6'($urandom_range(0, 9));
    else return 6'($urandom_range(18, 63));
  endfunction

  // One clock: check outputs at the falling edge against the model, then advance the model.
  task automatic step();
    iq_entry_t inc, h;
    bit have, ls, disp, bypassed, exp_full;
    @(negedge clk);
    issue_Vj = $urandom; issue_Vk = $urandom;
    issue_Qj = 4'($urandom); issue_Qk = 4'($urandom);
    issue_Pj = 1'($urandom); issue_Pk = 1'($urandom);
    #1;
    inc = '{op: op, rs1: rs1, rs2: rs2, rd: rd, imm: imm, pc: IF_curPC, pred: IF_pred_result};
    have = 1'b0; bypassed = 1'b0; h = inc;
    if (exp_q.size() > 0) begin have = 1'b1; h = exp_q[0]; end
    else if (BYP && ID_valid) begin have = 1'b1; bypassed = 1'b1; end
    ls = (h.op >= OP_LB) && (h.op <= OP_SW);
    disp = !rst && rdy && !jump_rst && have && !ROB_full && (ls ? !SLB_full : !RS_full);
    exp_full = (exp_q.size() == DEPTH);
    if (!rst) check("iq_full", iq_full, exp_full);
    check("ROB_send", ROB_send, disp);
    check("rename_send", rename_send, disp);
    check("RS_send", RS_send, disp && !ls);
    check("SLB_send", SLB_send, disp && ls);
    check("Vj_pass", Vj, issue_Vj);
    check("Qk_pass", Qk, issue_Qk);
    if (!rst && have) begin
      check("query_rs1", query_rs1, h.rs1);
      check("query_rs2", query_rs2, h.rs2);
    end
    if (disp) begin
      check("issue_curPC", issue_curPC, h.pc);
      check("issue_op", issue_op, h.op);
      check("issue_imm", issue_imm, h.imm);
      check("issue_pred", issue_pred, h.pred);
      check("rename_reg", rename_reg, h.rd);
      check("issue_reg", issue_reg, h.rd);
      check("issue_reorder", issue_reorder, ROB_tail);
      check("rename_reorder", rename_reorder, ROB_tail);
    end
    if (RS_send === 1'b1) rs_pulses++;
    if (SLB_send === 1'b1) slb_pulses++;
    if (rst) exp_q.delete();
    else if (rdy) begin
      if (jump_rst) exp_q.delete();
      else begin
        if (disp && !bypassed) void'(exp_q.pop_front());
        if (ID_valid && !exp_full && !(bypassed && disp)) exp_q.push_back(inc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_rst = 1'b0; ID_valid = 1'b1;
    ROB_full = 1'b0; RS_full = 1'b0; SLB_full = 1'b0; ROB_tail = 4'd3;
    issue_Vj = '0; issue_Vk = '0; issue_Qj = '0; issue_Qk = '0; issue_Pj = 1'b0; issue_Pk = 1'b0;
    set_instr(OP_ADD);

    // T1 reset with ID_valid held high
    repeat (2) step();
    rst = 1'b0; ID_valid = 1'b0;
    step();
    check("T1_full_after_rst", iq_full, 1'b0);

    // T2 fill with RS blocked, then drain
    RS_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ID_valid = 1'b1; set_instr(OP_ADD);
      step();
    end
    ID_valid = 1'b0;
    check("T2_full", iq_full, 1'b1);
    check("T2_depth", exp_q.size(), 8);
    RS_full = 1'b0; rs_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      ROB_tail = 4'($urandom); step();
    end
    check("T2_drain_pulses", rs_pulses, 8);
    check("T2_empty_full", iq_full, 1'b0);

    // T3 LW then ADD behind a full SLB
    SLB_full = 1'b1; rs_pulses = 0; slb_pulses = 0;
    ID_valid = 1'b1; set_instr(OP_LW); step();
    set_instr(OP_ADD); step();
    ID_valid = 1'b0;
    repeat (3) step();
    check("T3_stall_rs", rs_pulses, 0);
    check("T3_stall_slb", slb_pulses, 0);
    SLB_full = 1'b0;
    ROB_tail = 4'd5; step();
    check("T3_slb_first", slb_pulses, 1);
    check("T3_rs_not_yet", rs_pulses, 0);
    ROB_tail = 4'd6; step();
    check("T3_rs_second", rs_pulses, 1);

    // T4 flush with 5 queued and a new instruction arriving
    RS_full = 1'b1; ID_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin set_instr(OP_ADD); step(); end
    jump_rst = 1'b1; set_instr(OP_ADD); step();
    jump_rst = 1'b0; ID_valid = 1'b0;
    check("T4_flushed", exp_q.size(), 0);
    RS_full = 1'b0; step();
    ID_valid = 1'b1; set_instr(OP_ADD); step();
    ID_valid = 1'b0; repeat (2) step();

    // T5 rdy low holds three queued entries
    RS_full = 1'b1; ID_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin set_instr(6'($urandom_range(18, 63))); step(); end
    ID_valid = 1'b0; RS_full = 1'b0; rdy = 1'b0; rs_pulses = 0;
    repeat (4) step();
    check("T5_hold", rs_pulses, 0);
    rdy = 1'b1;
    repeat (4) step();
    check("T5_resume", rs_pulses, 3);

    // T6 single ADD into an empty queue
    rs_pulses = 0;
    ID_valid = 1'b1; set_instr(OP_ADD); step();
    ID_valid = 1'b0;
    check("T6_same_cycle", rs_pulses, BYP ? 1 : 0);
    step();
    check("T6_total", rs_pulses, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      rdy      = ($urandom_range(0, 9) != 0);
      jump_rst = ($urandom_range(0, 39) == 0);
      ID_valid = ($urandom_range(0, 9) < 6);
      ROB_full = ($urandom_range(0, 9) < 2);
      RS_full  = ($urandom_range(0, 9) < 3);
      SLB_full = ($urandom_range(0, 9) < 3);
      ROB_tail = 4'($urandom);
      set_instr(rand_op());
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
